// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file scoreboard slice.
package regfile_scoreboard_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]   reg_vec_t;
endpackage

// File: rtl/regfile_scoreboard_decoder.sv
// 5-to-32 select decoder: one-hot output when enabled, all zero otherwise.
module regfile_scoreboard_decoder
  import regfile_scoreboard_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] sel,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/regfile_scoreboard_reg_cell.sv
// Single register: synchronous active-high reset, load on enable.
module regfile_scoreboard_reg_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock) begin
    if (reset)       q <= '0;
    else if (enable) q <= d;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file, one write and two read ports with write bypass,
// plus a per-register busy scoreboard for pending writebacks.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic                  ctrl_reserve,
  input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB
);
  reg_vec_t write_hot;
  reg_vec_t reserve_hot;
  reg_vec_t busy;
  word_t    regs [NUM_REGS];

  localparam reg_vec_t NONZERO_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  regfile_scoreboard_decoder u_write_dec (
    .sel    (ctrl_writeReg),
    .en     (ctrl_writeEnable),
    .onehot (write_hot)
  );

  regfile_scoreboard_decoder u_reserve_dec (
    .sel    (ctrl_reserveReg),
    .en     (ctrl_reserve),
    .onehot (reserve_hot)
  );

  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
    regfile_scoreboard_reg_cell #(.WIDTH(DATA_WIDTH)) u_cell (
      .clock  (clock),
      .reset  (ctrl_reset),
      .enable (write_hot[i]),
      .d      (data_writeReg),
      .q      (regs[i])
    );
  end

  // A reservation in the same cycle as a write wins: the writeback it
  // announces is newer than the one completing now.
  always_ff @(posedge clock) begin
    if (ctrl_reset) busy <= '0;
    else            busy <= (reserve_hot | (busy & ~write_hot)) & NONZERO_MASK;
  end

  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    if (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegA && ctrl_readRegA != REG_ZERO)
      data_readRegA = data_writeReg;
  end

  always_comb begin
    data_readRegB = regs[ctrl_readRegB];
    if (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegB && ctrl_readRegB != REG_ZERO)
      data_readRegB = data_writeReg;
  end

  assign busy_readRegA = busy[ctrl_readRegA];
  assign busy_readRegB = busy[ctrl_readRegB];
endmodule
